lsu_ctrl: RTL and testbench

- Load/store sequencer that consumes the decoder's memory controls: mem write enable and 5-bit access mask (mask[3:0] = byte lanes, mask[4] = unsigned load).
- Accepts one access at a time, drives a word-aligned data-memory bus with a req/ack handshake, and splits misaligned accesses into two word transactions.
- Returns merged, sign- or zero-extended load data to writeback.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_lane_align.sv | 32 +++
 rtl/lsu_ctrl.sv | 163 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// lsu_pkg: access-mask codes, sequencer state encoding and mask legality check
// shared by the load/store unit files.
package lsu_pkg;

  localparam logic [4:0] MASK_B  = 5'b00001;
  localparam logic [4:0] MASK_H  = 5'b00011;
  localparam logic [4:0] MASK_W  = 5'b01111;
  localparam logic [4:0] MASK_BU = 5'b10001;
  localparam logic [4:0] MASK_HU = 5'b10011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  // Unsigned variants only make sense for loads.
  function automatic logic is_legal_mask(input logic [4:0] mask, input logic wr);
    logic known;
    known = (mask == MASK_B) || (mask == MASK_H) || (mask == MASK_W) ||
            (mask == MASK_BU) || (mask == MASK_HU);
    return known && !(mask[4] && wr);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// lsu_lane_align: byte-lane placement of store data/enables across two words and
// extraction plus sign/zero extension of load data from the captured read words.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [4:0]  mask,
  input  logic [31:0] wdata,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  output logic [7:0]  be8,
  output logic [63:0] wd64,
  output logic [31:0] ldata
);

  logic [31:0] raw;

  always_comb begin
    be8  = {4'b0000, mask[3:0]} << off;
    wd64 = {32'd0, wdata} << {off, 3'b000};
    raw  = 32'({hi, lo} >> {off, 3'b000});

    case (mask[3:0])
      MASK_B[3:0]: ldata = mask[4] ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      MASK_H[3:0]: ldata = mask[4] ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default:     ldata = raw;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// lsu_ctrl: single-outstanding load/store sequencer driving a word-aligned req/ack
// memory bus; misaligned accesses are split into two word transactions.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_vld,
  output logic        o_req_rdy,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_wr,
  input  logic [4:0]  i_mask,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_rsp_vld,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

  state_t        state, state_nx;
  logic [31:0]   addr_r, wdata_r, lo_r, hi_r;
  logic          wr_r, err_r, gap_r;
  logic [4:0]    mask_r;
  logic [CW-1:0] cnt;

  logic [7:0]    be8;
  logic [63:0]   wd64;
  logic [31:0]   ldata;
  logic          split, timeout_hit;
  logic [31:0]   base_addr, next_addr;

  lsu_lane_align u_align (
    .off   (addr_r[1:0]),
    .mask  (mask_r),
    .wdata (wdata_r),
    .lo    (lo_r),
    .hi    (hi_r),
    .be8   (be8),
    .wd64  (wd64),
    .ldata (ldata)
  );

  assign split       = |be8[7:4];
  assign timeout_hit = (TIMEOUT_CYC > 0) && (cnt == TO_LAST);
  assign base_addr   = {addr_r[31:2], 2'b00};
  assign next_addr   = {addr_r[31:2] + 30'd1, 2'b00};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= IDLE;
      addr_r  <= '0;
      wdata_r <= '0;
      wr_r    <= 1'b0;
      mask_r  <= '0;
      err_r   <= 1'b0;
      lo_r    <= '0;
      hi_r    <= '0;
      cnt     <= '0;
      gap_r   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (i_req_vld) begin
            addr_r  <= i_addr;
            wdata_r <= i_wdata;
            wr_r    <= i_wr;
            mask_r  <= i_mask;
            err_r   <= !is_legal_mask(i_mask, i_wr);
            lo_r    <= '0;
            hi_r    <= '0;
            cnt     <= '0;
            gap_r   <= 1'b0;
          end
        end
        ACC0: begin
          if (i_mem_ack) begin
            if (!wr_r) lo_r <= i_mem_rdata;
            cnt   <= '0;
            gap_r <= 1'b1;
          end else if (timeout_hit) begin
            err_r <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ACC1: begin
          // One idle bus cycle separates the two halves of a split access.
          if (gap_r) begin
            gap_r <= 1'b0;
          end else if (i_mem_ack) begin
            if (!wr_r) hi_r <= i_mem_rdata;
          end else if (timeout_hit) begin
            err_r <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx    = state;
    o_req_rdy   = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_addr  = '0;
    o_mem_we    = 1'b0;
    o_mem_be    = '0;
    o_mem_wdata = '0;
    o_rsp_vld   = 1'b0;
    o_rsp_rdata = '0;
    o_rsp_err   = 1'b0;

    case (state)
      IDLE: begin
        o_req_rdy = 1'b1;
        if (i_req_vld) state_nx = is_legal_mask(i_mask, i_wr) ? ACC0 : RESP;
      end
      ACC0: begin
        o_mem_req   = 1'b1;
        o_mem_addr  = base_addr;
        o_mem_we    = wr_r;
        o_mem_be    = be8[3:0];
        o_mem_wdata = wd64[31:0];
        if (i_mem_ack)        state_nx = split ? ACC1 : RESP;
        else if (timeout_hit) state_nx = RESP;
      end
      ACC1: begin
        if (!gap_r) begin
          o_mem_req   = 1'b1;
          o_mem_addr  = next_addr;
          o_mem_we    = wr_r;
          o_mem_be    = be8[7:4];
          o_mem_wdata = wd64[63:32];
          if (i_mem_ack || timeout_hit) state_nx = RESP;
        end
      end
      RESP: begin
        o_rsp_vld   = 1'b1;
        o_rsp_err   = err_r;
        o_rsp_rdata = (wr_r || err_r) ? 32'd0 : ldata;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// tb_lsu_ctrl: directed tests of the load/store sequencer against a small
// combinational memory responder with controllable acknowledge.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic [31:0] addr = '0, wdata = '0;
  logic        wr = 1'b0;
  logic [4:0]  mask = '0;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        rsp_vld, rsp_err;
  logic [31:0] rsp_rdata;

  logic        ack_en = 1'b1;
  logic [31:0] mem_a [4];
  logic [31:0] mem_d [4];

  int tests = 0, fails = 0;
  int nlog = 0, req_cycles = 0, rsp_cnt = 0;
  logic [31:0] log_addr [16];
  logic [31:0] log_wd   [16];
  logic [3:0]  log_be   [16];
  logic        log_we   [16];

  lsu_ctrl #(.TIMEOUT_CYC(4)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req_vld(req_vld), .o_req_rdy(req_rdy),
    .i_addr(addr), .i_wdata(wdata), .i_wr(wr), .i_mask(mask),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .o_mem_we(mem_we),
    .o_mem_be(mem_be), .o_mem_wdata(mem_wdata),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_rsp_vld(rsp_vld), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  assign mem_ack = mem_req & ack_en;

  always_comb begin
    mem_rdata = 32'd0;
    for (int i = 0; i < 4; i++)
      if (mem_a[i] == mem_addr) mem_rdata = mem_d[i];
  end

  always @(posedge clk) begin
    if (mem_req) req_cycles <= req_cycles + 1;
    if (rsp_vld) rsp_cnt <= rsp_cnt + 1;
    if (mem_req && mem_ack) begin
      log_addr[nlog % 16] <= mem_addr;
      log_wd[nlog % 16]   <= mem_wdata;
      log_be[nlog % 16]   <= mem_be;
      log_we[nlog % 16]   <= mem_we;
      nlog <= nlog + 1;
    end
  end

  // Issues one access and reports the response cycle (1 = cycle after accept, 0 = none).
  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic w,
                       input logic [4:0] m, output int n, output logic [31:0] rd,
                       output logic e);
    n = 0; rd = 32'd0; e = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 50 && !req_rdy; k++) @(negedge clk);
    req_vld = 1'b1; addr = a; wdata = wd; wr = w; mask = m;
    @(posedge clk); #1;
    req_vld = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (rsp_vld) begin
        n = k; rd = rsp_rdata; e = rsp_err;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (req_rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy: got %b want 1", req_rdy); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    tests++; if (rsp_vld !== 1'b0) begin fails++; $display("FAIL reset_rsp_vld: got %b want 0", rsp_vld); end
    tests++; if ({mem_addr, mem_be, mem_we, mem_wdata} !== 69'd0) begin fails++; $display("FAIL reset_bus: got addr %h be %b", mem_addr, mem_be); end
    tests++; if ({rsp_rdata, rsp_err} !== 33'd0) begin fails++; $display("FAIL reset_rsp: got %h err %b want 0", rsp_rdata, rsp_err); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (req_rdy !== 1'b1 || mem_req !== 1'b0) begin fails++; $display("FAIL post_reset_idle: got rdy %b req %b want 1 0", req_rdy, mem_req); end
  endtask

  task automatic test_aligned_lw;
    int n, l0; logic [31:0] rd; logic e;
    mem_a[0] = 32'h100; mem_d[0] = 32'hDEADBEEF;
    l0 = nlog;
    issue(32'h100, 32'd0, 1'b0, 5'b01111, n, rd, e);
    tests++; if (n !== 2) begin fails++; $display("FAIL lw_latency: got %0d want 2", n); end
    tests++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin fails++; $display("FAIL lw_data: got %h err %b want deadbeef 0", rd, e); end
    tests++; if (nlog - l0 !== 1) begin fails++; $display("FAIL lw_txn_count: got %0d want 1", nlog - l0); end
    tests++; if (log_addr[l0 % 16] !== 32'h100 || log_be[l0 % 16] !== 4'b1111 || log_we[l0 % 16] !== 1'b0)
      begin fails++; $display("FAIL lw_bus: got addr %h be %b we %b want 100 1111 0", log_addr[l0 % 16], log_be[l0 % 16], log_we[l0 % 16]); end
    @(posedge clk); #1;
    tests++; if (rsp_vld !== 1'b0) begin fails++; $display("FAIL lw_pulse_width: got %b want 0", rsp_vld); end
  endtask

  task automatic test_byte_loads;
    int n, l0; logic [31:0] rd; logic e;
    mem_a[0] = 32'h100; mem_d[0] = 32'h80000000;
    l0 = nlog;
    issue(32'h103, 32'd0, 1'b0, 5'b00001, n, rd, e);
    tests++; if (rd !== 32'hFFFFFF80 || e !== 1'b0) begin fails++; $display("FAIL lb_data: got %h err %b want ffffff80 0", rd, e); end
    tests++; if (log_be[l0 % 16] !== 4'b1000 || log_addr[l0 % 16] !== 32'h100) begin fails++; $display("FAIL lb_bus: got be %b addr %h want 1000 100", log_be[l0 % 16], log_addr[l0 % 16]); end
    issue(32'h103, 32'd0, 1'b0, 5'b10001, n, rd, e);
    tests++; if (rd !== 32'h00000080 || n !== 2) begin fails++; $display("FAIL lbu_data: got %h cyc %0d want 00000080 2", rd, n); end
  endtask

  task automatic test_misaligned_sw;
    int n, l0; logic [31:0] rd; logic e;
    l0 = nlog;
    issue(32'h0FE, 32'h11223344, 1'b1, 5'b01111, n, rd, e);
    tests++; if (n !== 4) begin fails++; $display("FAIL sw_split_latency: got %0d want 4", n); end
    tests++; if (nlog - l0 !== 2) begin fails++; $display("FAIL sw_txn_count: got %0d want 2", nlog - l0); end
    tests++; if (log_addr[l0 % 16] !== 32'h0FC || log_be[l0 % 16] !== 4'b1100 || log_wd[l0 % 16] !== 32'h33440000 || log_we[l0 % 16] !== 1'b1)
      begin fails++; $display("FAIL sw_req1: got addr %h be %b wd %h we %b want 0fc 1100 33440000 1", log_addr[l0 % 16], log_be[l0 % 16], log_wd[l0 % 16], log_we[l0 % 16]); end
    tests++; if (log_addr[(l0+1) % 16] !== 32'h100 || log_be[(l0+1) % 16] !== 4'b0011 || log_wd[(l0+1) % 16] !== 32'h00001122)
      begin fails++; $display("FAIL sw_req2: got addr %h be %b wd %h want 100 0011 00001122", log_addr[(l0+1) % 16], log_be[(l0+1) % 16], log_wd[(l0+1) % 16]); end
    tests++; if (rd !== 32'd0 || e !== 1'b0) begin fails++; $display("FAIL sw_rsp: got %h err %b want 0 0", rd, e); end
  endtask

  task automatic test_misaligned_lh;
    int n, l0; logic [31:0] rd; logic e;
    mem_a[0] = 32'h200; mem_d[0] = 32'hAB000000;
    mem_a[1] = 32'h204; mem_d[1] = 32'h000000CD;
    issue(32'h203, 32'd0, 1'b0, 5'b00011, n, rd, e);
    tests++; if (rd !== 32'hFFFFCDAB || n !== 4) begin fails++; $display("FAIL lh_split: got %h cyc %0d want ffffcdab 4", rd, n); end
    mem_a[2] = 32'hFFFFFFFC; mem_d[2] = 32'h34000000;
    mem_a[3] = 32'h0;        mem_d[3] = 32'h00000012;
    l0 = nlog;
    issue(32'hFFFFFFFF, 32'd0, 1'b0, 5'b00011, n, rd, e);
    tests++; if (log_addr[l0 % 16] !== 32'hFFFFFFFC || log_addr[(l0+1) % 16] !== 32'h0)
      begin fails++; $display("FAIL lh_wrap_addr: got %h %h want fffffffc 0", log_addr[l0 % 16], log_addr[(l0+1) % 16]); end
    tests++; if (rd !== 32'h00001234 || e !== 1'b0) begin fails++; $display("FAIL lh_wrap_data: got %h err %b want 00001234 0", rd, e); end
  endtask

  task automatic test_errors;
    int n, rc0; logic [31:0] rd; logic e;
    rc0 = req_cycles;
    issue(32'h100, 32'd0, 1'b0, 5'b00111, n, rd, e);
    tests++; if (e !== 1'b1 || rd !== 32'd0 || n < 1 || n > 2) begin fails++; $display("FAIL bad_mask: got err %b data %h cyc %0d want 1 0 <=2", e, rd, n); end
    issue(32'h100, 32'hFF, 1'b1, 5'b10001, n, rd, e);
    tests++; if (e !== 1'b1 || n < 1 || n > 2) begin fails++; $display("FAIL store_unsigned: got err %b cyc %0d want 1 <=2", e, n); end
    tests++; if (req_cycles !== rc0) begin fails++; $display("FAIL err_no_bus: got %0d req cycles want 0", req_cycles - rc0); end
  endtask

  task automatic test_timeout;
    int n, rc0, l0; logic [31:0] rd; logic e;
    ack_en = 1'b0;
    rc0 = req_cycles; l0 = nlog;
    issue(32'h300, 32'd0, 1'b0, 5'b01111, n, rd, e);
    tests++; if (req_cycles - rc0 !== 4) begin fails++; $display("FAIL timeout_req_hold: got %0d want 4", req_cycles - rc0); end
    tests++; if (e !== 1'b1 || rd !== 32'd0 || n !== 5) begin fails++; $display("FAIL timeout_rsp: got err %b data %h cyc %0d want 1 0 5", e, rd, n); end
    tests++; if (nlog !== l0) begin fails++; $display("FAIL timeout_no_ack: got %0d txns want 0", nlog - l0); end
    ack_en = 1'b1;
  endtask

  task automatic test_reset_mid;
    int n, r0; logic [31:0] rd; logic e;
    @(negedge clk);
    for (int k = 0; k < 50 && !req_rdy; k++) @(negedge clk);
    req_vld = 1'b1; addr = 32'h0FE; wdata = 32'h11223344; wr = 1'b1; mask = 5'b01111;
    @(posedge clk); #1;
    req_vld = 1'b0;
    tests++; if (mem_req !== 1'b1 || mem_be !== 4'b1100) begin fails++; $display("FAIL mid_acc0: got req %b be %b want 1 1100", mem_req, mem_be); end
    @(posedge clk); #1;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL mid_gap: got req %b want 0", mem_req); end
    ack_en = 1'b0;
    @(posedge clk); #1;
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'b0011) begin fails++; $display("FAIL mid_acc1: got req %b addr %h be %b want 1 100 0011", mem_req, mem_addr, mem_be); end
    r0 = rsp_cnt;
    #2 rst = 1'b1;
    #1;
    tests++; if (mem_req !== 1'b0 || req_rdy !== 1'b1) begin fails++; $display("FAIL mid_reset_async: got req %b rdy %b want 0 1", mem_req, req_rdy); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (rsp_cnt !== r0) begin fails++; $display("FAIL mid_reset_no_rsp: got %0d responses want 0", rsp_cnt - r0); end
    ack_en = 1'b1;
    mem_a[0] = 32'h100; mem_d[0] = 32'hDEADBEEF;
    issue(32'h100, 32'd0, 1'b0, 5'b01111, n, rd, e);
    tests++; if (rd !== 32'hDEADBEEF || e !== 1'b0 || n !== 2) begin fails++; $display("FAIL after_reset_lw: got %h err %b cyc %0d want deadbeef 0 2", rd, e, n); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin mem_a[i] = 32'h1; mem_d[i] = 32'd0; end
    test_reset;
    test_aligned_lw;
    test_byte_loads;
    test_misaligned_sw;
    test_misaligned_lh;
    test_errors;
    test_timeout;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
